ram_arbiter_2p: RTL and testbench

- Shares the single-port byte-write data RAM between the core's instruction-fetch port (IF, read-only) and data-memory port (DM, read/write).
- Performs per-cycle arbitration with a req/gnt handshake and drives the RAM port.
- Routes the 1-cycle-latency read/write response back to the winning requester.
- Sits between the rvj1 core memory ports and the block RAM in the tb/support memory subsystem.

---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 50 +++++
 rtl/ram_arbiter_2p.sv | 116 +++++++++++
 tb/tb_ram_arbiter_2p.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ============================================================================
//  Module   : ram_arb_pkg
//  Purpose  : Shared types and constants for the two-port RAM arbiter.
//             WE_WIDTH     - byte-enable width of the shared RAM port.
//             port_e       - requester index (IF = bit 0, DM = bit 1).
//             resp_owner_t - one-hot {dm, if} ownership of a RAM cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  localparam int WE_WIDTH = 4;

  // One bit wide so it can index the 2-bit request/grant vectors directly.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

  typedef logic [1:0] resp_owner_t;

endpackage : ram_arb_pkg

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-entry round-robin grant logic used when RAM_ARB_RR_EN is
//             defined. A lone requester always wins; on contention the
//             preferred port wins and preference then flips to the loser.
//  Ports    : clk_i  - clock
//             rst_i  - synchronous active-high reset (forces gnt_o to 0)
//             req_i  - requests, indexed by port_e ({dm, if})
//             gnt_o  - one-hot combinational grants, indexed by port_e
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 0 = DM preferred, 1 = IF preferred
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (!rst_i) begin
      if (req_i[PORT_DM] && req_i[PORT_IF]) begin
        if (prio_q) gnt_o[PORT_IF] = 1'b1;
        else        gnt_o[PORT_DM] = 1'b1;
      end else begin
        gnt_o = req_i;
      end
      // Prefer whichever port did not just win.
      if (gnt_o[PORT_DM])      prio_d = 1'b1;
      else if (gnt_o[PORT_IF]) prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/ram_arbiter_2p.sv
// ============================================================================
//  Module   : ram_arbiter_2p
//  Purpose  : Shares one single-port byte-write RAM between the core's
//             instruction-fetch port (IF, read-only) and data port (DM,
//             read/write). Per-cycle req/gnt arbitration; the winner drives
//             the RAM in the grant cycle and receives rvalid one cycle later.
//  Config   : RAM_ARB_RR_EN - when defined, round-robin arbitration (rr_arb2);
//             otherwise fixed priority DM over IF.
//  Ports    : clk_i, rst_i        - clock, synchronous active-high reset
//             if_req/addr/gnt     - IF request handshake
//             if_rvalid/rdata     - IF response
//             dm_req/we/addr/wdata/gnt - DM request handshake (we=0 is read)
//             dm_rvalid/rdata     - DM response (read data or write ack)
//             ram_we/addr/wdata   - RAM command port
//             ram_rdata_i         - RAM read data, one cycle after address
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,

  input  logic                  dm_req_i,
  input  logic [WE_WIDTH-1:0]   dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,

  output logic [WE_WIDTH-1:0]   ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  resp_owner_t resp_owner_q;
  resp_owner_t resp_owner_d;

  always_comb begin
    w_req          = 2'b00;
    w_req[PORT_IF] = if_req_i;
    w_req[PORT_DM] = dm_req_i;
  end

`ifdef RAM_ARB_RR_EN
  rr_arb2 u_rr_arb2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (w_req),
    .gnt_o (w_gnt)
  );
`else
  // Fixed priority: DM wins whenever it requests.
  always_comb begin
    w_gnt = 2'b00;
    if (!rst_i) begin
      if (w_req[PORT_DM])      w_gnt[PORT_DM] = 1'b1;
      else if (w_req[PORT_IF]) w_gnt[PORT_IF] = 1'b1;
    end
  end
`endif

  assign if_gnt_o = w_gnt[PORT_IF];
  assign dm_gnt_o = w_gnt[PORT_DM];

  // Winner drives the RAM; an idle cycle presents an all-zero command.
  always_comb begin
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (w_gnt[PORT_DM]) begin
      ram_we_o    = dm_we_i;
      ram_addr_o  = dm_addr_i;
      ram_wdata_o = dm_wdata_i;
    end else if (w_gnt[PORT_IF]) begin
      ram_addr_o  = if_addr_i;
    end
  end

  // Ownership of the response that the RAM returns next cycle.
  always_comb begin
    resp_owner_d = w_gnt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) resp_owner_q <= '0;
    else       resp_owner_q <= resp_owner_d;
  end

  // The response of a grant issued just before reset is dropped: rvalid is
  // masked while reset is asserted, since the owner flop only clears at the
  // edge that ends that cycle.
  assign if_rvalid_o = resp_owner_q[PORT_IF] & ~rst_i;
  assign dm_rvalid_o = resp_owner_q[PORT_DM] & ~rst_i;

  assign if_rdata_o = ram_rdata_i;
  assign dm_rdata_o = ram_rdata_i;

endmodule : ram_arbiter_2p

`default_nettype wire

// File: tb/tb_ram_arbiter_2p.sv
// ============================================================================
//  Module   : tb_ram_arbiter_2p
//  Purpose  : Directed self-checking bench for ram_arbiter_2p with a
//             behavioural 1-cycle-latency byte-write RAM attached. RAM words
//             power up as 32'hC0DE0000 | address.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter_2p;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic [3:0]    dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_arbiter_2p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_gnt_o    (dm_gnt),
    .dm_rvalid_o (dm_rvalid),
    .dm_rdata_o  (dm_rdata),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: read-first, byte enables.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 4'h0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic dm_cmd(input logic [3:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 10'h020;
    dm_cmd(4'hF, 10'h011, 32'h12345678);
    #1;
    n_cmp++; if (dm_gnt !== 1'b0) begin n_err++; $display("FAIL reset_dm_gnt: got %b want 0", dm_gnt); end
    n_cmp++; if (if_gnt !== 1'b0) begin n_err++; $display("FAIL reset_if_gnt: got %b want 0", if_gnt); end
    n_cmp++; if (ram_we !== 4'h0) begin n_err++; $display("FAIL reset_ram_we: got %h want 0", ram_we); end
    tick();
    n_cmp++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got if=%b dm=%b want 0 0", if_rvalid, dm_rvalid); end
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin n_err++; $display("FAIL post_reset_rvalid: got if=%b dm=%b want 0 0", if_rvalid, dm_rvalid); end
  endtask

  task automatic test_single_port();
    dm_cmd(4'hF, 10'h010, 32'hDEADBEEF);
    #1;
    n_cmp++; if (dm_gnt !== 1'b1) begin n_err++; $display("FAIL sp_wr_gnt: got %b want 1", dm_gnt); end
    n_cmp++; if (ram_we !== 4'hF || ram_addr !== 10'h010 || ram_wdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL sp_wr_ram: got we=%h a=%h d=%h want F 010 deadbeef", ram_we, ram_addr, ram_wdata); end
    tick();
    n_cmp++; if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin n_err++; $display("FAIL sp_wr_rvalid: got dm=%b if=%b want 1 0", dm_rvalid, if_rvalid); end
    dm_cmd(4'h0, 10'h010, 32'h0);
    #1;
    n_cmp++; if (dm_gnt !== 1'b1 || ram_we !== 4'h0) begin n_err++; $display("FAIL sp_rd_gnt: got gnt=%b we=%h want 1 0", dm_gnt, ram_we); end
    tick();
    idle_inputs();
    n_cmp++; if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin n_err++; $display("FAIL sp_rd_rvalid: got dm=%b if=%b want 1 0", dm_rvalid, if_rvalid); end
    n_cmp++; if (dm_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sp_rd_data: got %h want deadbeef", dm_rdata); end
    tick();
    n_cmp++; if (dm_rvalid !== 1'b0) begin n_err++; $display("FAIL sp_rvalid_drop: got %b want 0", dm_rvalid); end
  endtask

  task automatic test_byte_write();
    dm_cmd(4'hF, 10'h040, 32'h11223344); tick();
    dm_cmd(4'b0010, 10'h040, 32'h0000AB00);
    #1;
    n_cmp++; if (ram_we !== 4'b0010) begin n_err++; $display("FAIL bw_ram_we: got %b want 0010", ram_we); end
    tick();
    dm_cmd(4'h0, 10'h040, 32'h0); tick();
    idle_inputs();
    n_cmp++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h1122AB44) begin
      n_err++; $display("FAIL bw_rdata: got v=%b d=%h want 1 1122ab44", dm_rvalid, dm_rdata); end
    tick();
  endtask

`ifndef RAM_ARB_RR_EN
  task automatic test_contention_fixed();
    if_req = 1'b1; if_addr = 10'h020;
    dm_cmd(4'h0, 10'h030, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || ram_addr !== 10'h030) begin
        n_err++; $display("FAIL fix_cont_c%0d: got dm=%b if=%b a=%h want 1 0 030", c, dm_gnt, if_gnt, ram_addr); end
      tick();
      n_cmp++; if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0 || dm_rdata !== 32'hC0DE0030) begin
        n_err++; $display("FAIL fix_cont_rv%0d: got dm=%b if=%b d=%h want 1 0 c0de0030", c, dm_rvalid, if_rvalid, dm_rdata); end
    end
    dm_req = 1'b0;
    #1;
    n_cmp++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || ram_addr !== 10'h020 || ram_we !== 4'h0) begin
      n_err++; $display("FAIL fix_if_gnt: got if=%b dm=%b a=%h we=%h want 1 0 020 0", if_gnt, dm_gnt, ram_addr, ram_we); end
    tick();
    idle_inputs();
    n_cmp++; if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0 || if_rdata !== 32'hC0DE0020) begin
      n_err++; $display("FAIL fix_if_rvalid: got if=%b dm=%b d=%h want 1 0 c0de0020", if_rvalid, dm_rvalid, if_rdata); end
    tick();
  endtask
`else
  task automatic test_contention_rr();
    logic [5:0] exp_dm;
    exp_dm = 6'b010101; // bit c: DM expected in cycle c (DM,IF,DM,IF,DM,IF)
    rst = 1'b1; idle_inputs(); tick(); rst = 1'b0;
    if_req = 1'b1; if_addr = 10'h020;
    dm_cmd(4'h0, 10'h030, 32'h0);
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if (dm_gnt !== exp_dm[c] || if_gnt !== ~exp_dm[c]) begin
        n_err++; $display("FAIL rr_gnt_c%0d: got dm=%b if=%b want %b %b", c, dm_gnt, if_gnt, exp_dm[c], ~exp_dm[c]); end
      tick();
      n_cmp++; if (dm_rvalid !== exp_dm[c] || if_rvalid !== ~exp_dm[c]) begin
        n_err++; $display("FAIL rr_rvalid_c%0d: got dm=%b if=%b want %b %b", c, dm_rvalid, if_rvalid, exp_dm[c], ~exp_dm[c]); end
    end
    idle_inputs();
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = 10'h005;
    #1;
    n_cmp++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt0: got %b want 1", if_gnt); end
    tick();
    if_addr = 10'h006;
    #1;
    n_cmp++; if (if_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== 32'hC0DE0005) begin
      n_err++; $display("FAIL b2b_overlap: got gnt=%b v=%b d=%h want 1 1 c0de0005", if_gnt, if_rvalid, if_rdata); end
    tick();
    idle_inputs();
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hC0DE0006) begin
      n_err++; $display("FAIL b2b_second: got v=%b d=%h want 1 c0de0006", if_rvalid, if_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 10'h007;
    #1;
    n_cmp++; if (if_gnt !== 1'b1) begin n_err++; $display("FAIL rm_if_gnt: got %b want 1", if_gnt); end
    tick();
    rst = 1'b1;
    dm_cmd(4'hF, 10'h050, 32'hFFFFFFFF);
    #1;
    n_cmp++; if (if_rvalid !== 1'b0) begin n_err++; $display("FAIL rm_rvalid_suppressed: got %b want 0", if_rvalid); end
    n_cmp++; if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || ram_we !== 4'h0) begin
      n_err++; $display("FAIL rm_in_reset: got if=%b dm=%b we=%h want 0 0 0", if_gnt, dm_gnt, ram_we); end
    tick();
    rst = 1'b0;
    dm_cmd(4'h0, 10'h050, 32'h0);
    #1;
    n_cmp++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_err++; $display("FAIL rm_first_grant: got dm=%b if=%b want 1 0", dm_gnt, if_gnt); end
    n_cmp++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin n_err++; $display("FAIL rm_post_rvalid: got if=%b dm=%b want 0 0", if_rvalid, dm_rvalid); end
    tick();
    idle_inputs();
    n_cmp++; if (dm_rdata !== 32'hC0DE0050) begin n_err++; $display("FAIL rm_no_write: got %h want c0de0050", dm_rdata); end
    tick();
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (ram_we !== 4'h0 || ram_addr !== '0 || ram_wdata !== '0 || if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
        n_err++; $display("FAIL idle_c%0d: got we=%h a=%h d=%h ifv=%b dmv=%b want all 0", c, ram_we, ram_addr, ram_wdata, if_rvalid, dm_rvalid); end
      tick();
    end
  endtask

  task automatic test_addr_max();
    dm_cmd(4'h0, 10'h3FF, 32'h0);
    #1;
    n_cmp++; if (ram_addr !== 10'h3FF) begin n_err++; $display("FAIL amax_addr: got %h want 3ff", ram_addr); end
    tick();
    idle_inputs();
    n_cmp++; if (dm_rdata !== 32'hC0DE03FF) begin n_err++; $display("FAIL amax_data: got %h want c0de03ff", dm_rdata); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'hC0DE0000 | i;
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_single_port();
    test_byte_write();
`ifndef RAM_ARB_RR_EN
    test_contention_fixed();
`else
    test_contention_rr();
`endif
    test_back_to_back();
    test_reset_mid();
    test_idle();
    test_addr_max();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ram_arbiter_2p

`default_nettype wire
